// File: rtl/inst_fetch_resp_if.sv
// Fetch-responder bus: PC-side request, byte-wide memory port and completion outputs.
interface inst_fetch_resp_if;
  logic        ce;
  logic [31:0] pc;
  logic        busy;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        misalign;

  modport slave (
    input  ce, pc, mem_rdata,
    output busy, mem_re, mem_addr, inst, inst_pc, inst_valid, misalign
  );
  modport master (
    output ce, pc, mem_rdata,
    input  busy, mem_re, mem_addr, inst, inst_pc, inst_valid, misalign
  );
endinterface

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: four byte reads assembled little-endian into one instruction.
// Optional INST_ALIGN_CHECK_EN: misaligned pc completes at once with a NOP and misalign=1.
module inst_fetch_resp (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_resp_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_base;
  logic [1:0]  r_cnt;
  logic [23:0] r_buf;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_misalign;
  logic        w_busy;
  logic        w_accept;
  logic        w_misalign_req;

  assign w_busy   = (r_state == FETCH) || (r_state == DRAIN);
  assign w_accept = bus.ce && !w_busy;

`ifdef INST_ALIGN_CHECK_EN
  assign w_misalign_req = w_accept && (bus.pc[1:0] != 2'b00);
`else
  assign w_misalign_req = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = w_misalign_req ? DONE : FETCH;
        else          w_next = IDLE;
      end
      FETCH:   if (r_cnt == 2'd3) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_misalign <= 1'b0;
      if (w_accept) begin
        r_base <= bus.pc;
        r_cnt  <= '0;
        if (w_misalign_req) begin
          r_inst     <= 32'h0000_0013;
          r_inst_pc  <= bus.pc;
          r_misalign <= 1'b1;
        end
      end
      // Read data lags the read by one cycle, so FETCH with cnt=k captures byte k-1.
      if (r_state == FETCH) begin
        r_cnt <= r_cnt + 2'd1;
        case (r_cnt)
          2'd1:    r_buf[7:0]   <= bus.mem_rdata;
          2'd2:    r_buf[15:8]  <= bus.mem_rdata;
          2'd3:    r_buf[23:16] <= bus.mem_rdata;
          default: ;
        endcase
      end
      if (r_state == DRAIN) begin
        r_inst    <= {bus.mem_rdata, r_buf};
        r_inst_pc <= r_base;
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.mem_re     = (r_state == FETCH);
  assign bus.mem_addr   = (r_state == FETCH) ? (r_base + {30'd0, r_cnt}) : 32'd0;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_valid = (r_state == DONE);
  assign bus.misalign   = r_misalign;
endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-fetch responder: the memory side of the PC-register fetch interface. It accepts a 32-bit fetch address (`pc`) qualified by `ce` and reads four bytes from a byte-wide, one-cycle-latency instruction memory. It assembles them little-endian into a 32-bit instruction and presents it with a one-cycle `inst_valid` pulse. It sits between the PC stage and the instruction ROM/RAM, feeding the IF/ID pipeline register.

## Interface
- Parameters: none; all widths fixed (address 32, instruction 32, memory data 8).
- Reset is `rst`, synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `ce`  in  1  fetch request valid.
- `pc`  in  32  fetch byte address, sampled on acceptance.
- `busy`  out  1  high while a fetch is in progress; requests are ignored while high.
- `mem_re`  out  1  memory read enable, one byte per cycle.
- `mem_addr`  out  32  memory byte address.
- `mem_rdata`  in  8  read data, valid the cycle after `mem_re`.
- `inst`  out  32  assembled instruction; holds until next completion.
- `inst_pc`  out  32  address of the fetch that produced `inst`.
- `inst_valid`  out  1  one-cycle completion pulse.
- `misalign`  out  1  misaligned-fetch flag; see Configuration.

## Operation
- States:
  - IDLE: waiting for a request.
  - FETCH: issue 4 reads; 2-bit byte counter `cnt` counts 0..3.
  - DRAIN: capture the last byte.
  - DONE: completion cycle.
- `busy` = state is FETCH or DRAIN; combinational from the registered state.
- Accept: `ce`=1 and `busy`=0, i.e. in IDLE or DONE.
  - On acceptance: base <= `pc`, `cnt` <= 0, next state FETCH.
  - In IDLE/DONE with `ce`=0: next state IDLE.
- FETCH:
  - `mem_re`=1, `mem_addr` = base + `cnt`, modulo 2^32 (wraps FFFFFFFF -> 00000000).
  - `cnt` increments each cycle; after `cnt`=3, next state is DRAIN.
- Capture: in each cycle following a read, `mem_rdata` is stored into byte k of the instruction register (bits 8k+7:8k), k = 0..3.
  - Byte 3 is captured at the end of DRAIN; DRAIN then goes to DONE.
- DONE:
  - `inst_valid`=1; `inst` and `inst_pc` are updated to the new values.
  - A request accepted in DONE starts a new fetch back-to-back.
- `ce` dropping during FETCH/DRAIN does not abort; an accepted fetch always completes.
- `mem_re`=0 and `mem_addr`=0 outside FETCH.
- Reset values:
  - state IDLE, `busy`=0, `mem_re`=0, `mem_addr`=0;
  - `inst`=0, `inst_pc`=0, `inst_valid`=0, `misalign`=0, `cnt`=0.
- Reset mid-fetch aborts immediately to IDLE.
  - No `inst_valid` is produced for the aborted fetch.
  - `inst` and `inst_pc` are cleared to 0.

## Timing
Request accepted in cycle T:
- T+1..T+4: `mem_re`=1, `mem_addr` = pc, pc+1, pc+2, pc+3.
- T+2..T+5: bytes 0..3 arrive on `mem_rdata`.
- T+5: DRAIN.
- T+6: DONE, `inst_valid`=1, `inst`/`inst_pc` valid.

Summary figures:
- Latency from acceptance to `inst_valid`: 6 cycles.
- Maximum throughput: 1 instruction per 6 cycles (acceptance in DONE).
- `busy` is high in T+1..T+5 and low in T+6.

## Configuration
- `INST_ALIGN_CHECK_EN` defined:
  - An accepted request with `pc[1:0]`≠0 issues no memory reads.
  - Next cycle is DONE with `inst`=32'h00000013 (NOP), `inst_pc`=`pc`, `misalign`=1, `inst_valid`=1.
  - `misalign` is 1 only in that DONE cycle.
  - Aligned requests behave as normal with `misalign`=0.
- Not defined:
  - `pc[1:0]` is ignored; unaligned addresses are fetched bytewise from `pc` upward.
  - `misalign` is tied to 0.

## Test plan
- Reset check: hold `rst` 2 cycles with `ce`=1 -> all outputs 0, no `mem_re`; release -> first acceptance on the next cycle with `ce`=1.
- Basic fetch: pc=00000010, memory bytes 10..13 = 13,05,10,00 -> `mem_addr` 10,11,12,13 in T+1..T+4; at T+6 `inst`=00100513, `inst_pc`=00000010, `inst_valid` pulse 1 cycle.
- Back-to-back: hold `ce`=1 with pc changing every cycle -> accepted pcs are those sampled in IDLE/DONE cycles only; `inst_valid` every 6 cycles; `pc` changes during `busy` are ignored.
- Reset mid-fetch: assert `rst` at T+3 -> `mem_re`=0 and IDLE at T+4, `inst`=0, no `inst_valid`.
- Wrap (macro off): pc=FFFFFFFE -> `mem_addr` FFFFFFFE, FFFFFFFF, 00000000, 00000001; `inst` assembled little-endian from those bytes.
- Misalign (macro on): pc=00000006 -> no `mem_re`; at T+1 `inst_valid`=1, `inst`=00000013, `misalign`=1, `inst_pc`=00000006.
